rs232_bus_master: RTL
=====================

Name: rs232_bus_master

Overview:
- Serial-line bus initiator: a host on the RS232 line reads and writes words on the internal peripheral bus through a byte-stream command protocol.
- Sits between the rx/tx byte buffers of a serial line and the internal bus. It acts as the initiator end of the same stb/we/addr/ack interface that the serial device responds on.
- Used for debug and boot access while the CPU is halted.

Parameters:
byte_timeout, 5_000_000, idle clock cycles allowed between bytes of one command before the parser aborts to IDLE (no reply)
bus_timeout, 255, cycles bus_stb may stay high without bus_ack before the transaction is abandoned with a NAK reply

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rx_data  in  8  head byte of rx buffer; valid while rx_empty=0
rx_empty  in  1  rx buffer empty
rx_rd  out  1  one-cycle pop of rx buffer; rx_data sampled in the same cycle
tx_data  out  8  byte to transmit; valid when tx_wr=1
tx_full  in  1  tx buffer full
tx_wr  out  1  one-cycle push into tx buffer
bus_stb  out  1  bus strobe, held until bus_ack or timeout
bus_we  out  1  1=write, 0=read; stable while bus_stb=1
bus_addr  out  24  byte address; stable while bus_stb=1
bus_wdata  out  32  write data; stable while bus_stb=1
bus_rdata  in  32  read data; sampled in the bus_ack cycle
bus_ack  in  1  transaction complete
busy  out  1  1 whenever state is not IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0, including bus_addr and bus_wdata. Counters cleared. Reset mid-command discards the command with no reply.
- Protocol (all multi-byte fields big-endian):
  - Write: 0x57 'W', A2 A1 A0, D3 D2 D1 D0. Reply 0x06.
  - Read: 0x52 'R', A2 A1 A0. Reply D3 D2 D1 D0.
  - Any other command byte: reply 0x15 (NAK), return to IDLE.
- Byte intake: rx_rd=1 for exactly one cycle when rx_empty=0 and the state expects input. No consecutive rx_rd pulses; at least one cycle gap, so the buffer empty flag settles.
- States:
  - IDLE: on pop, capture cmd. 'W' or 'R' -> ADDR (byte count 0). Else -> NAK.
  - ADDR: shift 3 bytes into bus_addr, MSB first. After the 3rd byte: 'W' -> WDATA; 'R' -> BUS.
  - WDATA: shift 4 bytes into bus_wdata, MSB first. Then -> BUS.
  - BUS: bus_stb=1 on the first cycle of the state. bus_we=(cmd=='W'). Hold until bus_ack=1.
    - On ack: drop bus_stb in the next cycle. For a read, latch bus_rdata into the reply register.
    - Then -> REPLY (write: 1 byte 0x06; read: 4 bytes).
    - An ack in the very first stb cycle is legal (single-cycle ack).
  - Bus timeout: bus_timeout cycles with stb=1 and no ack -> drop stb, -> NAK.
  - REPLY: for each byte, when tx_full=0, tx_wr=1 for one cycle with tx_data = next byte (read data MSB first). Minimum one idle cycle between pushes. If tx_full=1, stall indefinitely; no timeout in REPLY. After the last byte -> IDLE.
  - NAK: push 0x15 when tx_full=0, -> IDLE.
- Byte timeout:
  - Counter runs in ADDR and WDATA, cleared on each popped byte.
  - Reaching byte_timeout -> IDLE silently.
  - IDLE itself never times out.
- bus_addr and bus_wdata hold their last values after a transaction and are not cleared.
- busy=0 only in IDLE.
- rx bytes arriving during BUS, REPLY or NAK stay in the rx buffer and are not popped until IDLE.

Test Plan:
1. Write, ack after 3 cycles: rx 57 00 01 20 DE AD BE EF -> bus_stb=1, bus_we=1, bus_addr=0x000120, bus_wdata=0xDEADBEEF for 3 cycles, then drops. tx 06. busy returns to 0.
2. Read, single-cycle ack: rx 52 FF FF C0 with bus_rdata=0x12345678 -> bus_we=0, bus_addr=0xFFFFC0. tx 12 34 56 78 in order. Exactly one stb cycle.
3. Bad command: rx 41 -> tx 15. No bus_stb. Next command 52 00 00 04 executes normally.
4. Bus timeout: bus_timeout=8, read with bus_ack never asserted -> stb high for exactly 8 cycles, then tx 15. State IDLE.
5. Byte timeout and tx back-pressure:
   - rx 57 00 then silence for byte_timeout cycles -> IDLE, no tx.
   - Then a read with tx_full=1 for 100 cycles -> no tx_wr while full; all 4 bytes delivered after release.
6. Async reset mid-read: assert rst while bus_stb=1 -> bus_stb, busy, rx_rd and tx_wr go to 0 immediately, no reply. After release, a new write completes with reply 06.

Source files
------------

// File: rtl/rs232_bus_master.sv
// Serial-line bus initiator: parses 'W'/'R' byte commands from the rx buffer,
// runs one transaction on the stb/we/addr/ack bus and streams the reply to tx.
module rs232_bus_master #(
    parameter int unsigned byte_timeout = 5_000_000,
    parameter int unsigned bus_timeout  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rx_rd,
    output logic [7:0]  tx_data,
    input  logic        tx_full,
    output logic        tx_wr,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [23:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADDR  = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] BUS   = 3'd3;
    localparam logic [2:0] REPLY = 3'd4;
    localparam logic [2:0] NAK   = 3'd5;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] ACK_B = 8'h06;
    localparam logic [7:0] NAK_B = 8'h15;

    localparam int BT_W = $clog2(byte_timeout + 1);
    localparam int BS_W = $clog2(bus_timeout + 1);
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(byte_timeout - 1);
    localparam logic [BS_W-1:0] BS_LAST = BS_W'(bus_timeout - 1);

    logic [2:0]      state;
    logic [7:0]      cmd;
    logic [1:0]      fld_cnt;
    logic [BT_W-1:0] byte_cnt;
    logic [BS_W-1:0] bus_cnt;
    logic [31:0]     reply;
    logic [2:0]      reply_left;
    logic            want_rx;

    // Handshake: rx_rd and tx_wr are registered one-cycle strobes. The pop or
    // push takes effect at the clock edge that ends the strobe cycle (rx_data is
    // captured at that edge), and every strobe is followed by at least one low
    // cycle so the buffer flags can settle before the next decision.
    assign want_rx   = (state == IDLE) || (state == ADDR) || (state == WDATA);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cmd        <= 8'h00;
            fld_cnt    <= 2'd0;
            byte_cnt   <= '0;
            bus_cnt    <= '0;
            reply      <= 32'h0;
            reply_left <= 3'd0;
            rx_rd      <= 1'b0;
            tx_wr      <= 1'b0;
            tx_data    <= 8'h00;
            bus_stb    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 24'h0;
            bus_wdata  <= 32'h0;
        end else begin
            rx_rd <= want_rx && !rx_empty && !rx_rd;
            tx_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_rd) begin
                        cmd      <= rx_data;
                        fld_cnt  <= 2'd0;
                        byte_cnt <= '0;
                        state    <= (rx_data == CMD_W || rx_data == CMD_R) ? ADDR : NAK;
                    end
                end
                ADDR: begin
                    if (rx_rd) begin
                        bus_addr <= {bus_addr[15:0], rx_data};
                        byte_cnt <= '0;
                        fld_cnt  <= fld_cnt + 2'd1;
                        if (fld_cnt == 2'd2) begin
                            fld_cnt <= 2'd0;
                            if (cmd == CMD_W) begin
                                state <= WDATA;
                            end else begin
                                state   <= BUS;
                                bus_stb <= 1'b1;
                                bus_we  <= 1'b0;
                                bus_cnt <= '0;
                            end
                        end
                    end else if (byte_cnt == BT_LAST) begin
                        state <= IDLE;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                WDATA: begin
                    if (rx_rd) begin
                        bus_wdata <= {bus_wdata[23:0], rx_data};
                        byte_cnt  <= '0;
                        fld_cnt   <= fld_cnt + 2'd1;
                        if (fld_cnt == 2'd3) begin
                            state   <= BUS;
                            bus_stb <= 1'b1;
                            bus_we  <= 1'b1;
                            bus_cnt <= '0;
                        end
                    end else if (byte_cnt == BT_LAST) begin
                        state <= IDLE;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        bus_stb <= 1'b0;
                        state   <= REPLY;
                        if (bus_we) begin
                            reply      <= {ACK_B, 24'h0};
                            reply_left <= 3'd1;
                        end else begin
                            reply      <= bus_rdata;
                            reply_left <= 3'd4;
                        end
                    end else if (bus_cnt == BS_LAST) begin
                        bus_stb <= 1'b0;
                        state   <= NAK;
                    end else begin
                        bus_cnt <= bus_cnt + 1'b1;
                    end
                end
                REPLY: begin
                    // No timeout here: a full tx buffer stalls the reply indefinitely.
                    if (!tx_full && !tx_wr) begin
                        tx_wr      <= 1'b1;
                        tx_data    <= reply[31:24];
                        reply      <= {reply[23:0], 8'h00};
                        reply_left <= reply_left - 3'd1;
                        if (reply_left == 3'd1) state <= IDLE;
                    end
                end
                NAK: begin
                    if (!tx_full && !tx_wr) begin
                        tx_wr   <= 1'b1;
                        tx_data <= NAK_B;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
